// File: rtl/pong_game_controller.sv
// Match-level sequencer for pong: consumes physics score flags, keeps both scores
// and holds the physics stage in reset except while a rally is in play.
module pong_game_controller #(
  parameter int unsigned WIN_SCORE          = 7,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned SCORE_W            = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [1:0]         player_did_score,
  output logic               physics_rst_n,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         point_pulse,
  output logic [2:0]         game_state,
  output logic [1:0]         winner
);

  localparam int unsigned CNT_W = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StGameOver = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]         pulse_q, pulse_d;
  logic [1:0]         winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               start_prev_q;
  logic               phys_q;
  logic               first_q, first_d;
  logic               start_rise;

  assign start_rise = start_btn & ~start_prev_q;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    pulse_d   = 2'b00;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    case (state_q)
      StIdle, StGameOver: begin
        if (start_rise) begin
          state_d   = StServe;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 2'b00;
          cnt_d     = '0;
        end
      end
      StServe: begin
        if (frame_tick) begin
          if (cnt_inc == SERVE_LAST) begin
            state_d = StPlay;
            cnt_d   = '0;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StPlay: begin
        // first_q masks stale flags while physics is still coming out of reset
        if (!first_q && player_did_score != 2'b00) begin
          score_l_d = score_l_q + SCORE_W'(player_did_score[0]);
          score_r_d = score_r_q + SCORE_W'(player_did_score[1]);
          pulse_d   = player_did_score;
          state_d   = StPoint;
        end
      end
      StPoint: begin
        if (score_l_q == WIN_VAL || score_r_q == WIN_VAL) begin
          state_d  = StGameOver;
          winner_d = {score_r_q == WIN_VAL, score_l_q == WIN_VAL};
        end else begin
          state_d = StServe;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      score_l_q    <= '0;
      score_r_q    <= '0;
      pulse_q      <= 2'b00;
      winner_q     <= 2'b00;
      cnt_q        <= '0;
      start_prev_q <= 1'b1;
      phys_q       <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      pulse_q      <= pulse_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_btn;
      phys_q       <= (state_d == StPlay);
      first_q      <= first_d;
    end
  end

  assign physics_rst_n = phys_q;
  assign score_left    = score_l_q;
  assign score_right   = score_r_q;
  assign point_pulse   = pulse_q;
  assign game_state    = state_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed match scenarios followed by random play, every cycle compared against
// a rule-level reference model of the match.
module tb_pong_game_controller;

  localparam int WIN   = 7;
  localparam int DELAY = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start_btn;
  logic [1:0] player_did_score;
  logic       physics_rst_n;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [1:0] point_pulse;
  logic [2:0] game_state;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: match phase plus the counts the rules talk about
  int m_phase, m_left, m_right, m_pulse, m_winner, m_phys;
  int m_ticks, m_play_cycles, m_btn_prev;

  pong_game_controller dut (
    .clk              (clk),
    .rst              (rst),
    .frame_tick       (frame_tick),
    .start_btn        (start_btn),
    .player_did_score (player_did_score),
    .physics_rst_n    (physics_rst_n),
    .score_left       (score_left),
    .score_right      (score_right),
    .point_pulse      (point_pulse),
    .game_state       (game_state),
    .winner           (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    if (!rst) begin
      m_phase = 0; m_left = 0; m_right = 0; m_pulse = 0; m_winner = 0;
      m_ticks = 0; m_phys = 0; m_btn_prev = 1; m_play_cycles = 0;
      return;
    end
    rise = start_btn && !m_btn_prev;
    m_btn_prev = start_btn;
    m_pulse = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (rise) begin
        m_phase = 1; m_left = 0; m_right = 0; m_winner = 0; m_ticks = 0;
      end
    end else if (m_phase == 1) begin
      if (frame_tick) m_ticks++;
      if (m_ticks == DELAY) begin
        m_phase = 2; m_ticks = 0; m_play_cycles = 0;
      end
    end else if (m_phase == 2) begin
      m_play_cycles++;
      if (m_play_cycles > 1 && player_did_score != 0) begin
        m_left  += player_did_score[0];
        m_right += player_did_score[1];
        m_pulse  = player_did_score;
        m_phase  = 3;
      end
    end else begin
      if (m_left == WIN || m_right == WIN) begin
        m_phase  = 4;
        m_winner = 2 * (m_right == WIN) + (m_left == WIN);
      end else begin
        m_phase = 1;
      end
    end
    m_phys = (m_phase == 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("state", game_state, m_phase);
    check("score_left", score_left, m_left);
    check("score_right", score_right, m_right);
    check("point_pulse", point_pulse, m_pulse);
    check("winner", winner, m_winner);
    check("physics_rst_n", physics_rst_n, m_phys);
  endtask

  task automatic press_start();
    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    start_btn = 1'b0;
  endtask

  // Ticks every cycle until the model reaches PLAY; returns ticks seen in SERVE
  task automatic wait_play(output int ticks);
    int n = 0;
    ticks = 0;
    player_did_score = 2'b00;
    while (m_phase != 2 && n < 300) begin
      frame_tick = 1'b1;
      if (game_state == 3'd1) ticks++;
      step();
      n++;
    end
    frame_tick = 1'b0;
    check("reach_play", game_state, 2);
  endtask

  task automatic score_point(input logic [1:0] flags);
    int t;
    wait_play(t);
    player_did_score = 2'($urandom_range(0, 3));
    step();
    player_did_score = flags;
    step();
    player_did_score = 2'b00;
    step();
  endtask

  initial begin
    int t;
    rst = 1'b0; frame_tick = 1'b0; start_btn = 1'b1; player_did_score = 2'b00;
    repeat (3) step();
    // Held button through reset release must not start
    rst = 1'b1;
    repeat (5) step();
    check("held_btn_idle", game_state, 0);
    press_start();
    check("serve_after_edge", game_state, 1);
    wait_play(t);
    check("serve_ticks", t, DELAY);
    check("phys_in_play", physics_rst_n, 1);
    // First PLAY cycle flags ignored
    player_did_score = 2'b11; step();
    check("first_play_ignored", game_state, 2);
    player_did_score = 2'b01; step();
    check("t2_left", score_left, 1);
    check("t2_pulse", point_pulse, 1);
    check("t2_point", game_state, 3);
    check("t2_phys", physics_rst_n, 0);
    player_did_score = 2'b00; step();
    check("t2_serve", game_state, 1);
    // Build 6-6 then simultaneous score -> draw
    repeat (5) score_point(2'b01);
    repeat (6) score_point(2'b10);
    score_point(2'b11);
    check("draw_left", score_left, 7);
    check("draw_right", score_right, 7);
    check("draw_winner", winner, 3);
    check("draw_over", game_state, 4);
    press_start();
    check("restart_left", score_left, 0);
    check("restart_state", game_state, 1);
    // 6-3 then left wins; later flags ignored
    repeat (6) score_point(2'b01);
    repeat (3) score_point(2'b10);
    score_point(2'b01);
    check("left_win", winner, 1);
    player_did_score = 2'b11; frame_tick = 1'b1;
    repeat (5) step();
    check("frozen_left", score_left, 7);
    check("frozen_right", score_right, 3);
    check("frozen_state", game_state, 4);
    // Reset in PLAY with a pending flag gives no credit
    player_did_score = 2'b00; frame_tick = 1'b0;
    press_start();
    wait_play(t);
    step();
    player_did_score = 2'b10; rst = 1'b0; step();
    check("rst_idle", game_state, 0);
    check("rst_score", score_right, 0);
    check("rst_pulse", point_pulse, 0);
    rst = 1'b1; player_did_score = 2'b00;
    // Random play
    for (int i = 0; i < 15000; i++) begin
      rst        = ($urandom_range(0, 999) != 0);
      frame_tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      player_did_score = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
